eth_tx_src_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the 10GbE frame-builder payload input between two AXI-Stream payload sources. On each grant it latches that source's destination MAC and EtherType onto the header outputs, which feed the frame builder's header inputs. It passes the granted stream through combinationally with full tready back-pressure. An oversize-packet watchdog truncates runaway packets and marks them bad with tuser.

---
 rtl/eth_tx_src_arbiter_if.sv | 16 +
 rtl/eth_tx_src_arbiter.sv | 114 +++++++++++
 tb/tb_eth_tx_src_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_src_arbiter_if.sv
// AXI-Stream payload link between a payload source, the source arbiter and
// the 10GbE frame builder.
interface eth_tx_src_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_tx_src_arbiter.sv
// Packet-granular round-robin arbiter between two payload sources feeding the
// frame builder, with per-grant header latching and an oversize-packet watchdog.
module eth_tx_src_arbiter #(
  parameter int DATA_W    = 64,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int MAX_BEATS = 190
) (
  input  logic                  cclk,
  input  logic                  reset,
  input  logic                  arb_en,
  eth_tx_src_arbiter_if.slave   s0_axis,
  input  logic [47:0]           s0_dMAC,
  input  logic [15:0]           s0_eType,
  eth_tx_src_arbiter_if.slave   s1_axis,
  input  logic [47:0]           s1_dMAC,
  input  logic [15:0]           s1_eType,
  eth_tx_src_arbiter_if.master  m_axis,
  output logic [47:0]           hdr_dMAC,
  output logic [15:0]           hdr_eType,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  trunc_err
);
  localparam int NUM_SRC = 2;
  localparam int CNT_W   = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, PASS, FLUSH} state_t;

  state_t             state;
  logic               rr_last;
  logic [CNT_W-1:0]   beat_cnt;

  logic [NUM_SRC-1:0][DATA_W-1:0] src_tdata;
  logic [NUM_SRC-1:0][KEEP_W-1:0] src_tkeep;
  logic [NUM_SRC-1:0]             src_tvalid, src_tlast, src_tuser, src_tready;

  assign src_tdata  = {s1_axis.tdata,  s0_axis.tdata};
  assign src_tkeep  = {s1_axis.tkeep,  s0_axis.tkeep};
  assign src_tvalid = {s1_axis.tvalid, s0_axis.tvalid};
  assign src_tlast  = {s1_axis.tlast,  s0_axis.tlast};
  assign src_tuser  = {s1_axis.tuser,  s0_axis.tuser};
  assign s0_axis.tready = src_tready[0];
  assign s1_axis.tready = src_tready[1];

  logic sel, in_pass, in_flush, at_limit, trunc_beat, xfer, flush_done, win;

  assign sel      = grant[1];
  assign in_pass  = (state == PASS);
  assign in_flush = (state == FLUSH);
  assign at_limit = (beat_cnt == CNT_W'(MAX_BEATS - 1));
  // Truncate only when the limit beat is not already the source's own tlast.
  assign trunc_beat = at_limit & ~src_tlast[sel];

  // Stream mux is driven only in PASS so GRANT gives the header a settle cycle.
  assign m_axis.tvalid = in_pass & src_tvalid[sel];
  assign m_axis.tdata  = in_pass ? src_tdata[sel] : '0;
  assign m_axis.tkeep  = in_pass ? src_tkeep[sel] : '0;
  assign m_axis.tlast  = in_pass & (src_tlast[sel] | at_limit);
  assign m_axis.tuser  = in_pass & (src_tuser[sel] | trunc_beat);

  assign xfer       = m_axis.tvalid & m_axis.tready;
  assign flush_done = in_flush & src_tvalid[sel] & src_tlast[sel];

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_rdy
      assign src_tready[i] = grant[i] & ((in_pass & m_axis.tready) | in_flush);
    end
  endgenerate

  // Both requesting: the source that did not go last wins.
  assign win  = (&src_tvalid) ? ~rr_last : src_tvalid[1];
  assign busy = (state != IDLE);

  always_ff @(posedge cclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 2'b00;
      rr_last   <= 1'b1;
      beat_cnt  <= '0;
      hdr_dMAC  <= '0;
      hdr_eType <= '0;
      trunc_err <= 1'b0;
    end else begin
      trunc_err <= 1'b0;
      case (state)
        IDLE: if (arb_en && |src_tvalid) begin
          grant     <= {win, ~win};
          hdr_dMAC  <= win ? s1_dMAC  : s0_dMAC;
          hdr_eType <= win ? s1_eType : s0_eType;
          beat_cnt  <= '0;
          state     <= GRANT;
        end
        GRANT: state <= PASS;
        PASS: if (xfer) begin
          beat_cnt <= beat_cnt + CNT_W'(1);
          if (src_tlast[sel]) begin
            state   <= IDLE;
            rr_last <= sel;
            grant   <= 2'b00;
          end else if (at_limit) begin
            trunc_err <= 1'b1;
            state     <= FLUSH;
          end
        end
        FLUSH: if (flush_done) begin
          state   <= IDLE;
          rr_last <= sel;
          grant   <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_src_arbiter.sv
// Randomized scoreboard bench for eth_tx_src_arbiter: packet-level model predicts
// grant order, truncation and header values; a monitor checks every output beat.
module tb_eth_tx_src_arbiter;
  localparam int MB = 4;

  logic cclk = 1'b0;
  logic reset, arb_en, m_rdy;
  always #5 cclk = ~cclk;

  eth_tx_src_arbiter_if s0_if ();
  eth_tx_src_arbiter_if s1_if ();
  eth_tx_src_arbiter_if m_if ();

  logic [47:0] s_dmac [2];
  logic [15:0] s_etype[2];
  logic [63:0] s_tdata[2];
  logic [7:0]  s_tkeep[2];
  logic        s_tvalid[2], s_tlast[2], s_tuser[2], s_rdy[2];
  logic [47:0] hdr_dmac;
  logic [15:0] hdr_etype;
  logic [1:0]  grant;
  logic        busy, trunc_err;

  assign s0_if.tdata = s_tdata[0];  assign s1_if.tdata = s_tdata[1];
  assign s0_if.tkeep = s_tkeep[0];  assign s1_if.tkeep = s_tkeep[1];
  assign s0_if.tvalid = s_tvalid[0]; assign s1_if.tvalid = s_tvalid[1];
  assign s0_if.tlast = s_tlast[0];  assign s1_if.tlast = s_tlast[1];
  assign s0_if.tuser = s_tuser[0];  assign s1_if.tuser = s_tuser[1];
  assign s_rdy[0] = s0_if.tready;   assign s_rdy[1] = s1_if.tready;
  assign m_if.tready = m_rdy;

  eth_tx_src_arbiter #(.MAX_BEATS(MB)) dut (
    .cclk(cclk), .reset(reset), .arb_en(arb_en),
    .s0_axis(s0_if), .s0_dMAC(s_dmac[0]), .s0_eType(s_etype[0]),
    .s1_axis(s1_if), .s1_dMAC(s_dmac[1]), .s1_eType(s_etype[1]),
    .m_axis(m_if), .hdr_dMAC(hdr_dmac), .hdr_eType(hdr_etype),
    .grant(grant), .busy(busy), .trunc_err(trunc_err)
  );

  typedef struct {
    int          len;
    logic [31:0] seed;
    logic        user;
    logic [7:0]  klast;
    logic [47:0] dmac;
    logic [15:0] etype;
  } pkt_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last, user, trunc;
    logic [47:0] dmac;
    logic [15:0] etype;
    logic [1:0]  grant;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0, errors = 0;
  int    rr = 1;
  int    rdy_mode = 0;
  bit    mon_en = 0;

  function automatic logic [63:0] beat_data(input logic [31:0] seed, input int i);
    return {seed, seed ^ (32'(i) * 32'h9E37_79B9)};
  endfunction

  function automatic pkt_t mk_pkt(input int len, input logic user,
                                  input logic [47:0] dmac, input logic [15:0] etype);
    pkt_t p;
    p.len = len; p.seed = $urandom; p.user = user; p.klast = 8'($urandom_range(1, 255));
    p.dmac = dmac; p.etype = etype;
    return p;
  endfunction

  function automatic pkt_t rand_pkt();
    return mk_pkt($urandom_range(1, 7), 1'($urandom_range(0, 1)),
                  48'({$urandom, $urandom}), 16'($urandom));
  endfunction

  // Output image of one packet: at most MB beats; an over-long packet ends at
  // beat MB with tlast and tuser forced high.
  function automatic void push_exp(input int src, input pkt_t p);
    int  n;
    bit  over;
    beat_t b;
    over = (p.len > MB);
    n    = over ? MB : p.len;
    for (int i = 0; i < n; i++) begin
      b.data  = beat_data(p.seed, i);
      b.keep  = (i == p.len - 1) ? p.klast : 8'hFF;
      b.last  = (i == n - 1);
      b.user  = (i == n - 1) && (over || p.user);
      b.trunc = over && (i == n - 1);
      b.dmac  = p.dmac;
      b.etype = p.etype;
      b.grant = (src == 1) ? 2'b10 : 2'b01;
      exp_q.push_back(b);
    end
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input int idx, input pkt_t p);
    int wd;
    s_dmac[idx] = p.dmac; s_etype[idx] = p.etype;
    for (int i = 0; i < p.len; i++) begin
      if (i > 0)
        while ($urandom_range(0, 3) == 0) begin
          s_tvalid[idx] = 1'b0; @(posedge cclk); #1;
        end
      s_tdata[idx]  = beat_data(p.seed, i);
      s_tkeep[idx]  = (i == p.len - 1) ? p.klast : 8'hFF;
      s_tlast[idx]  = (i == p.len - 1);
      s_tuser[idx]  = (i == p.len - 1) && p.user;
      s_tvalid[idx] = 1'b1;
      wd = 0;
      forever begin
        @(negedge cclk);
        if (s_rdy[idx]) begin @(posedge cclk); #1; break; end
        @(posedge cclk); #1;
        if (++wd > 500) begin
          checks++; errors++;
          $display("FAIL drv%0d_timeout: beat %0d never accepted, required accept within 500 cycles", idx, i);
          s_tvalid[idx] = 1'b0;
          return;
        end
      end
      // Header inputs may move once the packet is underway; the latch must ignore it.
      if (i == 0) begin s_dmac[idx] = 48'({$urandom, $urandom}); s_etype[idx] = 16'($urandom); end
    end
    s_tvalid[idx] = 1'b0; s_tlast[idx] = 1'b0; s_tuser[idx] = 1'b0;
  endtask

  task automatic round(input bit use0, input bit use1, input pkt_t p0, input pkt_t p1);
    if (use0 && use1) begin
      if (rr == 1) begin push_exp(0, p0); push_exp(1, p1); rr = 1; end
      else         begin push_exp(1, p1); push_exp(0, p0); rr = 0; end
    end else if (use0) begin push_exp(0, p0); rr = 0; end
    else if (use1)     begin push_exp(1, p1); rr = 1; end
    fork
      begin if (use0) drive(0, p0); end
      begin if (use1) drive(1, p1); end
    join
    repeat (3) @(posedge cclk);
    #1;
  endtask

  initial forever begin
    @(posedge cclk); #1;
    case (rdy_mode)
      1:       m_rdy = ($urandom_range(0, 2) != 0);
      2:       m_rdy = ~m_rdy;
      default: m_rdy = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on every accepted output beat.
  initial begin
    bit    trunc_pend;
    beat_t b;
    trunc_pend = 0;
    forever begin
      @(negedge cclk);
      if (!mon_en) trunc_pend = 0;
      else begin
        chk("trunc_err", 64'(trunc_err), 64'(trunc_pend));
        trunc_pend = 0;
        chk("both_tready", 64'(s_rdy[0] & s_rdy[1]), 64'd0);
        if (m_if.tvalid && m_rdy) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got data %h, required no beat", m_if.tdata);
          end else begin
            b = exp_q.pop_front();
            if ({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser, hdr_dmac, hdr_etype, grant} !==
                {b.data, b.keep, b.last, b.user, b.dmac, b.etype, b.grant}) begin
              errors++;
              $display("FAIL beat: got d=%h k=%h l=%b u=%b mac=%h et=%h g=%b expected d=%h k=%h l=%b u=%b mac=%h et=%h g=%b",
                       m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser, hdr_dmac, hdr_etype, grant,
                       b.data, b.keep, b.last, b.user, b.dmac, b.etype, b.grant);
            end
            trunc_pend = b.trunc;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    pkt_t a, c;
    reset = 1'b1; arb_en = 1'b0; m_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_dmac[i] = '0; s_etype[i] = '0; s_tdata[i] = '0; s_tkeep[i] = '0;
      s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0; s_tuser[i] = 1'b0;
    end
    repeat (3) @(posedge cclk);
    #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hdr", {hdr_dmac, hdr_etype}, 64'd0);
    chk("rst_trunc", 64'(trunc_err), 64'd0);
    chk("rst_m", {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tkeep, m_if.tdata[31:0]}, 64'd0);
    chk("rst_tready", {s_rdy[0], s_rdy[1]}, 64'd0);
    reset = 1'b0; arb_en = 1'b1; mon_en = 1; rr = 1;

    // Single source, fixed header.
    a = mk_pkt(4, 1'b0, 48'h0A0B0C0D0E0F, 16'h0800);
    round(1, 0, a, a);
    // Contention with 3-beat packets.
    for (int r = 0; r < 2; r++) begin
      a = mk_pkt(3, 1'b0, 48'h111111111111, 16'h0800);
      c = mk_pkt(3, 1'b0, 48'h222222222222, 16'h86DD);
      round(1, 1, a, c);
    end
    // Toggling back-pressure on s1 (5 beats exceed MB and truncate).
    rdy_mode = 2;
    c = rand_pkt(); c.len = 5; round(0, 1, c, c);
    c = rand_pkt(); c.len = 3; round(0, 1, c, c);
    rdy_mode = 0;
    // Watchdog, then exact-length packet, then normal grant.
    a = rand_pkt(); a.len = 7; round(1, 0, a, a);
    a = rand_pkt(); a.len = MB; a.user = 1'b0; round(1, 0, a, a);
    a = rand_pkt(); a.len = 2; c = rand_pkt(); round(1, 1, a, c);
    // Random traffic.
    rdy_mode = 1;
    for (int r = 0; r < 40; r++) begin
      int pick;
      pick = $urandom_range(0, 2);
      round(pick != 1, pick != 0, rand_pkt(), rand_pkt());
    end
    rdy_mode = 0;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    // arb_en low blocks a new grant.
    arb_en = 1'b0; s_tvalid[1] = 1'b1; s_tlast[1] = 1'b0;
    repeat (10) @(posedge cclk);
    #1;
    chk("arb_dis_grant", 64'(grant), 64'd0);
    chk("arb_dis_busy", 64'(busy), 64'd0);
    chk("arb_dis_tready", 64'(s_rdy[1]), 64'd0);
    s_tvalid[1] = 1'b0; arb_en = 1'b1;
    repeat (2) @(posedge cclk);
    #1;

    // Reset during beat 2 of an s0 packet.
    mon_en = 0;
    s_tdata[0] = 64'hDEAD_BEEF_0000_0001; s_tkeep[0] = 8'hFF; s_tlast[0] = 1'b0; s_tvalid[0] = 1'b1;
    repeat (3) @(posedge cclk);
    #1;
    chk("mid_pkt_grant", 64'(grant), 64'd1);
    chk("mid_pkt_tvalid", 64'(m_if.tvalid), 64'd1);
    @(negedge cclk);
    reset = 1'b1;
    #1;
    chk("rst_mid_grant", 64'(grant), 64'd0);
    chk("rst_mid_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_mid_tready", {s_rdy[0], s_rdy[1]}, 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    s_tvalid[0] = 1'b0;
    @(posedge cclk);
    #1;
    reset = 1'b0; rr = 1; mon_en = 1;
    round(1, 1, rand_pkt(), rand_pkt());
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
